if_prefetch: RTL and testbench

Parametrised instruction-fetch stage with decoupled request/response memory channels. It keeps up to MAX_OUTSTANDING fetches in flight and holds returned instructions in a FQ_DEPTH-entry fetch queue, so fetching continues while decode is stalled. A flush discards all queued and in-flight fetches and restarts at a redirect PC. It sits between the instruction memory port and decode, and replaces the single-entry fetch stage.

---
 rtl/if_prefetch.sv | 169 ++++++++++++++++
 tb/tb_if_prefetch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// if_prefetch : instruction fetch with in-order outstanding requests and a fetch queue
// Rev 1.0
// ============================================================================
module if_prefetch #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int              FQ_DEPTH        = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [XLEN-1:0]           i_redirect_pc,
  output logic                      o_imem_req_valid,
  input  logic                      i_imem_req_ready,
  output logic [XLEN-1:0]           o_imem_req_addr,
  input  logic                      i_imem_rsp_valid,
  input  logic [31:0]               i_imem_rsp_data,
  input  logic                      i_imem_rsp_err,
  output logic                      o_if_valid,
  output logic [XLEN-1:0]           o_if_pc,
  output logic [31:0]               o_if_instr,
  output logic                      o_if_err,
  output logic [$clog2(FQ_DEPTH):0] o_fq_count
);

  localparam int FQ_AW = $clog2(FQ_DEPTH);
  localparam int CNT_W = FQ_AW + 1;
  localparam int PD_AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W:0]   MAX_OUT_W  = (CNT_W+1)'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   FQ_DEPTH_W = (CNT_W+1)'(FQ_DEPTH);
  localparam logic [PD_AW-1:0] PD_LAST    = PD_AW'(MAX_OUTSTANDING - 1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_pc_q [MAX_OUTSTANDING];
  logic [XLEN-1:0]  pend_pc_d [MAX_OUTSTANDING];
  logic [PD_AW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [XLEN-1:0]  fq_pc_q    [FQ_DEPTH];
  logic [XLEN-1:0]  fq_pc_d    [FQ_DEPTH];
  logic [31:0]      fq_instr_q [FQ_DEPTH];
  logic [31:0]      fq_instr_d [FQ_DEPTH];
  logic             fq_err_q   [FQ_DEPTH];
  logic             fq_err_d   [FQ_DEPTH];
  logic [FQ_AW-1:0] fq_rd_q, fq_rd_d, fq_wr_q, fq_wr_d;
  logic [CNT_W-1:0] fq_cnt_q, fq_cnt_d;

  logic [CNT_W:0]   inflight;
  logic [CNT_W:0]   occupancy;
  logic             req_fire;
  logic             rsp_drop;
  logic             rsp_keep;
  logic             fq_pop;
  logic             unused_redirect_lsbs;

  function automatic logic [PD_AW-1:0] pd_inc(input logic [PD_AW-1:0] p);
    return (p == PD_LAST) ? '0 : p + PD_AW'(1);
  endfunction

  // Credits count pend+drop against the memory and pend+fq against the queue,
  // so every accepted request is guaranteed a queue slot on return.
  assign inflight  = {1'b0, pend_cnt_q} + {1'b0, drop_cnt_q};
  assign occupancy = {1'b0, pend_cnt_q} + {1'b0, fq_cnt_q};

  assign o_imem_req_valid = rst_n & ~i_flush & (inflight < MAX_OUT_W) & (occupancy < FQ_DEPTH_W);
  assign o_imem_req_addr  = pc_q;
  assign req_fire         = o_imem_req_valid & i_imem_req_ready;
  assign rsp_drop         = i_imem_rsp_valid & (drop_cnt_q != '0);
  assign rsp_keep         = i_imem_rsp_valid & (drop_cnt_q == '0);
  assign fq_pop           = (fq_cnt_q != '0) & ~i_stall & ~i_flush;

  assign o_if_valid = (fq_cnt_q != '0);
  assign o_if_pc    = fq_pc_q[fq_rd_q];
  assign o_if_instr = fq_instr_q[fq_rd_q];
  assign o_if_err   = fq_err_q[fq_rd_q];
  assign o_fq_count = fq_cnt_q;

  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  always_comb begin
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_rd_d  = pend_rd_q;
    pend_wr_d  = pend_wr_q;
    pend_cnt_d = pend_cnt_q;
    drop_cnt_d = drop_cnt_q;
    fq_pc_d    = fq_pc_q;
    fq_instr_d = fq_instr_q;
    fq_err_d   = fq_err_q;
    fq_rd_d    = fq_rd_q;
    fq_wr_d    = fq_wr_q;
    fq_cnt_d   = fq_cnt_q;

    if (i_flush) begin
      pc_d       = {i_redirect_pc[XLEN-1:2], 2'b00};
      pend_rd_d  = '0;
      pend_wr_d  = '0;
      pend_cnt_d = '0;
      fq_rd_d    = '0;
      fq_wr_d    = '0;
      fq_cnt_d   = '0;
      // A response landing in the flush cycle retires one of the in-flight
      // requests being converted to drops, and is itself discarded.
      drop_cnt_d = drop_cnt_q + pend_cnt_q - CNT_W'(i_imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pend_pc_d[pend_wr_q] = pc_q;
        pend_wr_d            = pd_inc(pend_wr_q);
        pc_d                 = pc_q + XLEN'(4);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CNT_W'(1);
      end
      if (rsp_keep) begin
        fq_pc_d[fq_wr_q]    = pend_pc_q[pend_rd_q];
        fq_instr_d[fq_wr_q] = i_imem_rsp_data;
        fq_err_d[fq_wr_q]   = i_imem_rsp_err;
        fq_wr_d             = fq_wr_q + FQ_AW'(1);
        pend_rd_d           = pd_inc(pend_rd_q);
      end
      if (fq_pop) begin
        fq_rd_d = fq_rd_q + FQ_AW'(1);
      end
      pend_cnt_d = pend_cnt_q + CNT_W'(req_fire) - CNT_W'(rsp_keep);
      fq_cnt_d   = fq_cnt_q + CNT_W'(rsp_keep) - CNT_W'(fq_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      pend_cnt_q <= '0;
      drop_cnt_q <= '0;
      fq_rd_q    <= '0;
      fq_wr_q    <= '0;
      fq_cnt_q   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        pend_pc_q[i] <= '0;
      end
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc_q[i]    <= '0;
        fq_instr_q[i] <= '0;
        fq_err_q[i]   <= 1'b0;
      end
    end else begin
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      pend_cnt_q <= pend_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      fq_pc_q    <= fq_pc_d;
      fq_instr_q <= fq_instr_d;
      fq_err_q   <= fq_err_d;
      fq_rd_q    <= fq_rd_d;
      fq_wr_q    <= fq_wr_d;
      fq_cnt_q   <= fq_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// tb_if_prefetch : self-checking bench for if_prefetch with an in-order memory model
// Rev 1.0
// ============================================================================
module tb_if_prefetch;

  localparam int XLEN     = 32;
  localparam int FQ_DEPTH = 4;
  localparam int MAX_OUT  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_stall, i_flush;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req_valid, req_ready;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid, i_imem_rsp_err;
  logic [31:0] i_imem_rsp_data;
  logic        o_if_valid, o_if_err;
  logic [31:0] o_if_pc, o_if_instr;
  logic [2:0]  o_fq_count;

  always #5 clk = ~clk;

  if_prefetch #(
    .XLEN(XLEN), .RESET_PC(32'h100), .FQ_DEPTH(FQ_DEPTH), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(req_ready),
    .o_imem_req_addr(o_imem_req_addr),
    .i_imem_rsp_valid(i_imem_rsp_valid), .i_imem_rsp_data(i_imem_rsp_data),
    .i_imem_rsp_err(i_imem_rsp_err),
    .o_if_valid(o_if_valid), .o_if_pc(o_if_pc), .o_if_instr(o_if_instr),
    .o_if_err(o_if_err), .o_fq_count(o_fq_count)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; logic err; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic stall; logic req; int cnt; logic valid; logic [31:0] pc; } vec_t;

  exp_t        sb[$];
  mreq_t       mem_q[$];
  vec_t        vec[16];
  int          cyc = 0;
  int          lat = 1;
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  logic [31:0] exp_pc = 32'h100;
  logic [31:0] err_addr = 32'h108;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    req_ready = 1'b1;
    mem_q.delete();
    sb.delete();
    exp_pc    = 32'h100;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Memory: in-order responses, lat cycles after the accepting cycle.
  initial begin
    mreq_t m;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = '0;
    i_imem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        m = mem_q.pop_front();
        i_imem_rsp_valid = 1'b1;
        i_imem_rsp_data  = instr_of(m.addr);
        i_imem_rsp_err   = (m.addr == err_addr);
      end else begin
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        i_imem_rsp_err   = 1'b0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    exp_t        e;
    logic        prev_wait;
    logic [31:0] prev_addr;
    prev_wait = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wait = 1'b0;
        exp_pc    = 32'h100;
      end else begin
        if (prev_wait && !i_flush) begin
          chk("req_hold_valid", o_imem_req_valid, 1);
          chk("req_hold_addr", o_imem_req_addr, prev_addr);
        end
        if (i_flush) begin
          chk("flush_no_req", o_imem_req_valid, 0);
          sb.delete();
          exp_pc = {i_redirect_pc[31:2], 2'b00};
        end else if (o_if_valid && !i_stall) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pop: got pc %0h expected no entry (cycle %0d)", o_if_pc, cyc);
          end else begin
            e = sb.pop_front();
            chk("pop_pc", o_if_pc, e.pc);
            chk("pop_instr", o_if_instr, e.instr);
            chk("pop_err", o_if_err, e.err);
            pops++;
          end
        end
        if (o_imem_req_valid && req_ready) begin
          chk("max_outstanding", (mem_q.size() + int'(i_imem_rsp_valid)) < MAX_OUT, 1);
          chk("req_addr", o_imem_req_addr, exp_pc);
          sb.push_back('{exp_pc, instr_of(exp_pc), exp_pc == err_addr});
          mem_q.push_back('{o_imem_req_addr, cyc + lat});
          exp_pc = exp_pc + 32'd4;
        end
        prev_wait = o_imem_req_valid & ~req_ready;
        prev_addr = o_imem_req_addr;
      end
    end
  end

  initial begin
    int n;
    i_stall = 1'b0; i_flush = 1'b0; i_redirect_pc = '0; req_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_if_valid", o_if_valid, 0);
    chk("rst_if_pc", o_if_pc, 0);
    chk("rst_if_instr", o_if_instr, 0);
    chk("rst_if_err", o_if_err, 0);
    chk("rst_fq_count", o_fq_count, 0);
    chk("rst_req_valid", o_imem_req_valid, 0);

    // Cycle-by-cycle from reset release, 1-cycle memory, stall 10 cycles then release.
    for (int i = 0; i < 10; i++) vec[i] = '{1'b1, 1'b0, 4, 1'b1, 32'h100};
    vec[0]  = '{1'b1, 1'b1, 0, 1'b0, 32'h0};
    vec[1]  = '{1'b1, 1'b1, 0, 1'b0, 32'h0};
    vec[2]  = '{1'b1, 1'b1, 1, 1'b1, 32'h100};
    vec[3]  = '{1'b1, 1'b1, 2, 1'b1, 32'h100};
    vec[4]  = '{1'b1, 1'b0, 3, 1'b1, 32'h100};
    vec[10] = '{1'b0, 1'b0, 4, 1'b1, 32'h100};
    vec[11] = '{1'b0, 1'b1, 3, 1'b1, 32'h104};
    vec[12] = '{1'b0, 1'b1, 2, 1'b1, 32'h108};
    vec[13] = '{1'b0, 1'b1, 2, 1'b1, 32'h10C};
    vec[14] = '{1'b0, 1'b1, 2, 1'b1, 32'h110};
    vec[15] = '{1'b0, 1'b1, 2, 1'b1, 32'h114};

    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_stall = vec[i].stall;
      @(negedge clk);
      chk($sformatf("vec%0d_req_valid", i), o_imem_req_valid, vec[i].req);
      chk($sformatf("vec%0d_fq_count", i), o_fq_count, vec[i].cnt);
      chk($sformatf("vec%0d_if_valid", i), o_if_valid, vec[i].valid);
      if (vec[i].valid) chk($sformatf("vec%0d_if_pc", i), o_if_pc, vec[i].pc);
      @(posedge clk);
      #1;
    end
    i_stall = 1'b0;

    // Flush with two requests in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    repeat (6) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    i_redirect_pc = 32'h2001;
    @(negedge clk);
    chk("flush1_inflight", mem_q.size() + int'(i_imem_rsp_valid), 2);
    @(posedge clk);
    #1 i_flush = 1'b0;
    @(negedge clk);
    chk("flush1_if_valid", o_if_valid, 0);
    chk("flush1_fq_count", o_fq_count, 0);
    n = 0;
    while (!o_if_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("flush1_timeout", n < 40, 1);
    chk("flush1_first_pc", o_if_pc, 32'h2000);
    repeat (10) begin @(posedge clk); #1; end

    // Flush coinciding with a response and a would-be pop.
    lat = 1;
    do_reset();
    repeat (8) begin @(posedge clk); #1; end
    i_flush = 1'b1;
    i_redirect_pc = 32'h3000;
    @(negedge clk);
    chk("flush2_rsp_present", i_imem_rsp_valid, 1);
    chk("flush2_head_valid", o_if_valid, 1);
    @(posedge clk);
    #1 i_flush = 1'b0;
    @(negedge clk);
    chk("flush2_fq_count", o_fq_count, 0);
    chk("flush2_if_valid", o_if_valid, 0);
    chk("flush2_req_valid", o_imem_req_valid, 1);
    chk("flush2_req_addr", o_imem_req_addr, 32'h3000);
    repeat (10) begin @(posedge clk); #1; end

    // Random stall / ready / flush on a 2-cycle memory.
    lat = 2;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      i_stall       = ($urandom_range(0, 2) == 0);
      req_ready     = ($urandom_range(0, 3) != 0);
      i_flush       = ($urandom_range(0, 39) == 0);
      i_redirect_pc = $urandom;
      @(posedge clk);
      #1;
    end
    i_stall = 1'b0; i_flush = 1'b0; req_ready = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    chk("progress", pops > 100, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
